// File: rtl/pwl_activation.sv
// pwl_activation: 3-stage piecewise-linear (PLAN) sigmoid on Q(DATA_W-FRAC_W).FRAC_W data.
// Optional tanh mode (2*sigmoid(2x)-1) is compiled in only when PWL_TANH_EN is defined.
module pwl_activation #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] x,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] f_x
);

   localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
   localparam logic [DATA_W-1:0] LSB      = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] MAX_CODE = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_CODE = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] ONE      = LSB << FRAC_W;

   // Segment breakpoints and offsets, built from power-of-two fractions of 1.0
   localparam logic [DATA_W-1:0] C_FIVE   = (ONE << 2) + ONE;
   localparam logic [DATA_W-1:0] C_2P375  = (ONE << 1) + (ONE >> 2) + (ONE >> 3);
   localparam logic [DATA_W-1:0] C_0P84375 = (ONE >> 1) + (ONE >> 2) + (ONE >> 4) + (ONE >> 5);
   localparam logic [DATA_W-1:0] C_0P625  = (ONE >> 1) + (ONE >> 3);
   localparam logic [DATA_W-1:0] C_HALF   = ONE >> 1;

   function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (v == MIN_CODE) begin
         r = MAX_CODE;
      end else if (v[DATA_W-1]) begin
         r = (~v) + LSB;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Sigmoid of a non-negative magnitude; shifts on a>=0 truncate toward zero
   function automatic logic [DATA_W-1:0] plan_seg(input logic [DATA_W-1:0] a);
      logic [DATA_W-1:0] r;
      if (a >= C_FIVE) begin
         r = ONE;
      end else if (a >= C_2P375) begin
         r = (a >> 5) + C_0P84375;
      end else if (a >= ONE) begin
         r = (a >> 3) + C_0P625;
      end else begin
         r = (a >> 2) + C_HALF;
      end
      return r;
   endfunction

`ifdef PWL_TANH_EN
   function automatic logic [DATA_W-1:0] sat_dbl(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (v[DATA_W-1] != v[DATA_W-2]) begin
         r = v[DATA_W-1] ? MIN_CODE : MAX_CODE;
      end else begin
         r = {v[DATA_W-2:0], 1'b0};
      end
      return r;
   endfunction
`endif

   logic              advance_s;
   logic [DATA_W-1:0] s1_src_s;
   logic              v1_r;
   logic              neg1_r;
   logic [DATA_W-1:0] mag1_r;
   logic              v2_r;
   logic              neg2_r;
   logic [DATA_W-1:0] sig2_r;
   logic [DATA_W-1:0] fold_s;
   logic [DATA_W-1:0] res_s;

   // The whole pipeline moves as one; it only freezes when the output is held
   assign advance_s = out_ready | ~out_valid;
   assign in_ready  = advance_s;

`ifdef PWL_TANH_EN
   logic mode1_r;
   logic mode2_r;

   assign s1_src_s = mode ? sat_dbl(x) : x;

   // Per-sample mode travels alongside the data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode1_r <= 1'b0;
         mode2_r <= 1'b0;
      end else if (advance_s) begin
         mode1_r <= mode;
         mode2_r <= mode1_r;
      end
   end
`else
   logic unused_mode_s;

   assign s1_src_s      = x;
   assign unused_mode_s = mode;
`endif

   // Stage 1: sign and saturated magnitude of the (possibly doubled) operand
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_r   <= 1'b0;
         neg1_r <= 1'b0;
         mag1_r <= ZERO;
      end else if (advance_s) begin
         v1_r   <= in_valid;
         neg1_r <= s1_src_s[DATA_W-1];
         mag1_r <= sat_abs(s1_src_s);
      end
   end

   // Stage 2: segment select and shift-add on the magnitude
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v2_r   <= 1'b0;
         neg2_r <= 1'b0;
         sig2_r <= ZERO;
      end else if (advance_s) begin
         v2_r   <= v1_r;
         neg2_r <= neg1_r;
         sig2_r <= plan_seg(mag1_r);
      end
   end

   // Stage 3 combinational: fold negatives to 1-f, then optional tanh rescale
   always_comb begin
      fold_s = sig2_r;
      res_s  = sig2_r;
      if (neg2_r) begin
         fold_s = ONE - sig2_r;
      end else begin
         fold_s = sig2_r;
      end
`ifdef PWL_TANH_EN
      if (mode2_r) begin
         res_s = {fold_s[DATA_W-2:0], 1'b0} - ONE;
      end else begin
         res_s = fold_s;
      end
`else
      res_s = fold_s;
`endif
   end

   // Stage 3 output register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         f_x       <= ZERO;
      end else if (advance_s) begin
         out_valid <= v2_r;
         f_x       <= res_s;
      end
   end

endmodule
